// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: opcodes, FSM states and reset PC shared by fetch and control.
package fetch_unit_pkg;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [5:0] OP_R_TYPE = 6'h00;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2b;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALTED} state_t;
endpackage

// File: rtl/fetch_unit_npc.sv
// fetch_unit_npc: combinational next-PC select between sequential, branch and jump targets.
module fetch_unit_npc (
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc
);
    logic [31:0] br_target;
    logic [31:0] j_target;
    always_comb begin
        pc_plus4  = pc + 32'd4;
        br_target = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
        j_target  = {pc_plus4[31:28], instr[25:0], 2'b00};
        next_pc   = jump ? j_target : (branch && zero) ? br_target : pc_plus4;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetches one word per instruction over req/ack, holds it for issue, retires on ex_ready.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          PC_W     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [5:0]      op_code,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus4,
    input  logic            ex_ready,
    input  logic            branch,
    input  logic            jump,
    input  logic            zero,
    input  logic            halt,
    output logic            halted,
    output logic [31:0]     instret
);
    state_t state, state_next;
    logic [PC_W-1:0] next_pc;
    logic load, retire;

    fetch_unit_npc u_npc (
        .pc(pc), .instr(instr), .branch(branch), .jump(jump), .zero(zero),
        .pc_plus4(pc_plus4), .next_pc(next_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = FETCH;
            FETCH:   state_next = imem_ack ? ISSUE : FETCH;
            ISSUE:   state_next = !ex_ready ? ISSUE : halt ? HALTED : FETCH;
            default: state_next = HALTED;
        endcase
    end

    always_comb begin
        imem_req    = state == FETCH;
        instr_valid = state == ISSUE;
        halted      = state == HALTED;
        imem_addr   = pc;
        op_code     = instr[31:26];
        load        = imem_req && imem_ack;
        retire      = instr_valid && ex_ready;
    end

    // branch/jump/zero only matter through next_pc, which is consumed solely at retire
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            instr   <= '0;
            instret <= '0;
        end else begin
            if (load) instr <= imem_rdata;
            if (retire) begin
                pc      <= next_pc;
                instret <= instret + 32'd1;
            end
        end
    end
endmodule
